xchg_reg_file: RTL

//  Parametrised register file with a 1-cycle registered host read port and a host write port.
//  An internal exchange engine runs SWAP, COPY and ZERO operations on two latched addresses.

---
 rtl/xchg_rf_pkg.sv | 17 +
 rtl/rf_storage.sv | 35 +++
 rtl/xchg_reg_file.sv | 91 +++++++++
 3 files changed

// File: rtl/xchg_rf_pkg.sv
// xchg_rf_pkg: operation codes and FSM state encoding for the exchange register file.
package xchg_rf_pkg;

    localparam logic [1:0] OP_SWAP = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_ZERO = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR_A = 3'd3,
        S_WR_B = 3'd4
    } state_t;

endpackage

// File: rtl/rf_storage.sv
// rf_storage: flop array with sync clear, registered host read port,
// combinational engine read port and a single write port.
module rf_storage #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] eng_addr,
    output logic [DATA_W-1:0] eng_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read samples the pre-write contents, so read-during-write returns old data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
            if (wr_en) mem[wr_addr] <= wr_data;
        end
    end

    assign eng_data = mem[eng_addr];

endmodule

// File: rtl/xchg_reg_file.sv
// xchg_reg_file: register file with host ports and a SWAP/COPY/ZERO exchange engine.
module xchg_reg_file
    import xchg_rf_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] address_w,
    input  logic [DATA_W-1:0] data_w,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] address_r,
    output logic [DATA_W-1:0] data_r,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_mode,
    input  logic [ADDR_W-1:0] address_A,
    input  logic [ADDR_W-1:0] address_B,
    output logic              busy,
    output logic              op_done,
    output logic              op_err
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] a_q, b_q, wr_addr, eng_addr;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] ta, tb, eng_data, wr_data;
    logic              idle, accept, eng_wr, wr_en;

    assign idle     = state == S_IDLE;
    assign wr_ready = idle;
    assign op_ready = idle;
    assign busy     = !idle;
    assign accept   = op_valid && idle;
    assign eng_wr   = state == S_WR_A || state == S_WR_B;
    assign wr_en    = eng_wr || (we && idle);
    assign eng_addr = state == S_RD_A ? a_q : b_q;
    assign wr_addr  = state == S_WR_A ? a_q : state == S_WR_B ? b_q : address_w;
    assign wr_data  = !eng_wr ? data_w : mode_q == OP_ZERO ? '0 : state == S_WR_A ? tb : ta;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = op_mode == OP_ZERO ? S_WR_A :
                                            op_mode == OP_RSVD ? S_IDLE : S_RD_A;
            S_RD_A:  state_nx = mode_q == OP_SWAP ? S_RD_B : S_WR_B;
            S_RD_B:  state_nx = S_WR_A;
            S_WR_A:  state_nx = S_WR_B;
            S_WR_B:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            op_done <= 1'b0;
            op_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            op_done <= state == S_WR_B || (accept && op_mode == OP_RSVD);
            op_err  <= accept && op_mode == OP_RSVD;
        end
    end

    // Operands are held here so the requester may change its inputs after accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q    <= address_A;
            b_q    <= address_B;
            mode_q <= op_mode;
        end
        if (state == S_RD_A) ta <= eng_data;
        if (state == S_RD_B) tb <= eng_data;
    end

    rf_storage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_storage (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_addr  (address_r),
        .rd_data  (data_r),
        .eng_addr (eng_addr),
        .eng_data (eng_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

endmodule
